// File: rtl/mem_refill_responder.sv
// Backing-memory responder for the IF/MA cache ports: one request at a time, fixed latency,
// wrapped critical-word-first line bursts or single-word writes. `MEMRESP_RR_ARB_EN selects round-robin arbitration.
module mem_refill_responder #(
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 3,
   parameter int ADDR_W     = 10
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        i_ireq,
   input  logic [31:0] i_iaddr,
   output logic        o_iack,
   output logic        o_ivalid,
   output logic [31:0] o_idata,
   output logic        o_ilast,
   input  logic        i_dreq,
   input  logic        i_dwe,
   input  logic [31:0] i_daddr,
   input  logic [31:0] i_dwdata,
   output logic        o_dack,
   output logic        o_dvalid,
   output logic [31:0] o_ddata,
   output logic        o_dlast
);

   localparam int WB = $clog2(LINE_WORDS);
   localparam int BW = WB + 1;
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     cnt_reg;
   logic [BW-1:0]     beats_reg;
   logic [ADDR_W-1:0] line_addr_reg;
   logic              we_reg;
   logic              port_d_reg;

   logic [31:0] mem [2**ADDR_W];

   logic        accept, grant_d, grant_i, emit, done;
   logic [31:0] sel_addr;
   logic [BW-1:0] total;
   logic [ADDR_W-1:0] rd_addr;
   logic        iack_next, dack_next, ivalid_next, dvalid_next, ilast_next, dlast_next;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_iaddr[31:ADDR_W+2], i_iaddr[1:0], i_daddr[31:ADDR_W+2], i_daddr[1:0]};

`ifdef MEMRESP_RR_ARB_EN
   logic last_d_reg;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         last_d_reg <= 1'b1;
      else if (accept)
         last_d_reg <= grant_d;
   end

   always_comb begin
      grant_d = i_dreq;
      if (i_dreq && i_ireq)
         grant_d = !last_d_reg;
      grant_i = i_ireq && !grant_d;
   end
`else
   always_comb begin
      grant_d = i_dreq;
      grant_i = i_ireq && !i_dreq;
   end
`endif

   assign accept   = (state_reg == IDLE) && (i_ireq || i_dreq);
   assign sel_addr = grant_d ? i_daddr : i_iaddr;
   assign total    = we_reg ? BW'(1) : BW'(LINE_WORDS);
   assign emit     = ((state_reg == WAIT) && (cnt_reg == CW'(1))) ||
                     ((state_reg == BURST) && (beats_reg != total));
   assign done     = (state_reg == BURST) && (beats_reg == total);

   // Word offset wraps within the line: the WB-bit add drops the carry.
   assign rd_addr = {line_addr_reg[ADDR_W-1:WB], line_addr_reg[WB-1:0] + beats_reg[WB-1:0]};

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = WAIT;
         WAIT:    if (cnt_reg == CW'(1)) state_next = BURST;
         BURST:   if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      iack_next   = accept && grant_i;
      dack_next   = accept && grant_d;
      ivalid_next = emit && !port_d_reg;
      dvalid_next = emit && port_d_reg;
      ilast_next  = ivalid_next && ((beats_reg + BW'(1)) == total);
      dlast_next  = dvalid_next && ((beats_reg + BW'(1)) == total);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         cnt_reg       <= '0;
         beats_reg     <= '0;
         line_addr_reg <= '0;
         we_reg        <= 1'b0;
         port_d_reg    <= 1'b0;
      end else begin
         if (accept) begin
            cnt_reg       <= CW'(LATENCY);
            beats_reg     <= '0;
            line_addr_reg <= sel_addr[ADDR_W+1:2];
            we_reg        <= grant_d && i_dwe;
            port_d_reg    <= grant_d;
         end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg - CW'(1);
         end
         if (emit)
            beats_reg <= beats_reg + BW'(1);
      end
   end

   // Writes land at the acceptance edge so any later read sees them.
   always_ff @(posedge Clk) begin
      if (accept && grant_d && i_dwe)
         mem[i_daddr[ADDR_W+1:2]] <= i_dwdata;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         o_iack   <= 1'b0;
         o_dack   <= 1'b0;
         o_ivalid <= 1'b0;
         o_dvalid <= 1'b0;
         o_ilast  <= 1'b0;
         o_dlast  <= 1'b0;
         o_idata  <= '0;
         o_ddata  <= '0;
      end else begin
         o_iack   <= iack_next;
         o_dack   <= dack_next;
         o_ivalid <= ivalid_next;
         o_dvalid <= dvalid_next;
         o_ilast  <= ilast_next;
         o_dlast  <= dlast_next;
         if (emit) begin
            if (port_d_reg)
               o_ddata <= we_reg ? 32'h0 : mem[rd_addr];
            else
               o_idata <= mem[rd_addr];
         end
      end
   end

endmodule

// File: tb/tb_mem_refill_responder.sv
// Directed self-checking bench for mem_refill_responder (default parameters).
// Tie expectations follow `MEMRESP_RR_ARB_EN when it is defined.
module tb_mem_refill_responder;

   localparam int LAT = 3;

   logic        Clk, Rst;
   logic        i_ireq, i_dreq, i_dwe;
   logic [31:0] i_iaddr, i_daddr, i_dwdata;
   logic        o_iack, o_ivalid, o_ilast, o_dack, o_dvalid, o_dlast;
   logic [31:0] o_idata, o_ddata;

   int checks = 0;
   int errors = 0;

   mem_refill_responder #(.LINE_WORDS(4), .LATENCY(LAT), .ADDR_W(10)) dut (
      .Clk(Clk), .Rst(Rst),
      .i_ireq(i_ireq), .i_iaddr(i_iaddr), .o_iack(o_iack), .o_ivalid(o_ivalid),
      .o_idata(o_idata), .o_ilast(o_ilast),
      .i_dreq(i_dreq), .i_dwe(i_dwe), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
      .o_dack(o_dack), .o_dvalid(o_dvalid), .o_ddata(o_ddata), .o_dlast(o_dlast)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        side_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp [4];
      int          nbeats;
   } vec_t;

   vec_t vecs [16];
   int   nv = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", nm, act, req);
      end
   endtask

   task automatic add_vec(input logic side_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3, input int n);
      vecs[nv].side_d = side_d;
      vecs[nv].we     = we;
      vecs[nv].addr   = addr;
      vecs[nv].wdata  = wdata;
      vecs[nv].exp[0] = e0;
      vecs[nv].exp[1] = e1;
      vecs[nv].exp[2] = e2;
      vecs[nv].exp[3] = e3;
      vecs[nv].nbeats = n;
      nv++;
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      logic g_ack, o_ack, g_val, o_val, g_last;
      logic [31:0] g_data;
      int k;
      @(negedge Clk);
      if (v.side_d) begin
         i_dreq = 1'b1; i_dwe = v.we; i_daddr = v.addr; i_dwdata = v.wdata;
      end else begin
         i_ireq = 1'b1; i_iaddr = v.addr;
      end
      @(posedge Clk);
      for (int c = 1; c <= LAT + v.nbeats; c++) begin
         @(negedge Clk);
         g_ack  = v.side_d ? o_dack   : o_iack;
         o_ack  = v.side_d ? o_iack   : o_dack;
         g_val  = v.side_d ? o_dvalid : o_ivalid;
         o_val  = v.side_d ? o_ivalid : o_dvalid;
         g_last = v.side_d ? o_dlast  : o_ilast;
         g_data = v.side_d ? o_ddata  : o_idata;
         chk($sformatf("v%0d_c%0d_ack", idx, c), {g_ack, o_ack}, {(c == 1), 1'b0});
         if (c == 1) begin
            i_ireq = 1'b0;
            i_dreq = 1'b0;
         end
         if (c <= LAT) begin
            chk($sformatf("v%0d_c%0d_novalid", idx, c), {g_val, o_val}, 2'b00);
         end else begin
            k = c - LAT - 1;
            chk($sformatf("v%0d_c%0d_beat", idx, c), {g_val, o_val, g_last, g_data},
                {1'b1, 1'b0, (k == v.nbeats - 1), v.exp[k]});
         end
      end
      @(negedge Clk);
      chk($sformatf("v%0d_gap", idx), {o_ivalid, o_dvalid, o_iack, o_dack}, 4'b0000);
      $display("txn %0d side=%s we=%0b addr=%h beats=%0d", idx, v.side_d ? "D" : "I",
               v.we, v.addr, v.nbeats);
   endtask

   initial begin
      logic owner_d;
      int   blk, pos;

      Rst = 1'b1;
      i_ireq = 1'b0; i_dreq = 1'b0; i_dwe = 1'b0;
      i_iaddr = '0; i_daddr = '0; i_dwdata = '0;

      add_vec(1, 1, 32'h20, 32'hA0, 0, 0, 0, 0, 1);
      add_vec(1, 1, 32'h24, 32'hA1, 0, 0, 0, 0, 1);
      add_vec(1, 1, 32'h28, 32'hA2, 0, 0, 0, 0, 1);
      add_vec(1, 1, 32'h2C, 32'hA3, 0, 0, 0, 0, 1);
      add_vec(0, 0, 32'h24, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 4);
      add_vec(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 1);
      add_vec(1, 0, 32'h40, 0, 32'hDEADBEEF, 32'hX, 32'hX, 32'hX, 1);
      nv--;  // replaced below once the rest of the line is written
      add_vec(1, 1, 32'h44, 32'h11111111, 0, 0, 0, 0, 1);
      add_vec(1, 1, 32'h48, 32'h22222222, 0, 0, 0, 0, 1);
      add_vec(1, 1, 32'h4C, 32'h33333333, 0, 0, 0, 0, 1);
      add_vec(1, 0, 32'h40, 0, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333, 4);
      add_vec(1, 0, 32'h48, 0, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 32'h11111111, 4);
      add_vec(0, 0, 32'h1000_0024, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 4);
      add_vec(1, 0, 32'h2C, 0, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 4);
      add_vec(0, 0, 32'h20, 0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4);

      repeat (2) @(negedge Clk);
      chk("reset_outputs",
          {o_iack, o_ivalid, o_ilast, o_idata, o_dack, o_dvalid, o_dlast, o_ddata}, '0);
      Rst = 1'b0;

      for (int i = 0; i < nv; i++)
         run_txn(vecs[i], i);

      // Reset in cycle 5 of an instruction burst.
      @(negedge Clk);
      i_ireq = 1'b1; i_iaddr = 32'h24;
      @(posedge Clk);
      @(negedge Clk);
      chk("rst_seq_ack", o_iack, 1'b1);
      i_ireq = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      chk("rst_seq_beat1", {o_ivalid, o_idata}, {1'b1, 32'hA2});
      #1 Rst = 1'b1;
      #1;
      chk("rst_seq_clear",
          {o_iack, o_ivalid, o_ilast, o_idata, o_dack, o_dvalid, o_dlast, o_ddata}, '0);
      @(negedge Clk);
      Rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge Clk);
         chk($sformatf("rst_seq_quiet%0d", c), {o_ivalid, o_dvalid, o_iack, o_dack}, 4'b0000);
      end
      $display("txn rst_mid_burst addr=00000024");

      // Both ports request together and hold; acceptances every 8 cycles.
      @(negedge Clk);
      i_ireq = 1'b1; i_iaddr = 32'h40;
      i_dreq = 1'b1; i_dwe = 1'b0; i_daddr = 32'h20;
      @(posedge Clk);
      for (int c = 1; c <= 24; c++) begin
         @(negedge Clk);
         blk = (c - 1) / 8;
         pos = (c - 1) % 8 + 1;
`ifdef MEMRESP_RR_ARB_EN
         owner_d = (blk % 2) == 1;
`else
         owner_d = 1'b1;
`endif
         chk($sformatf("tie_c%0d", c), {o_iack, o_dack, o_ivalid, o_dvalid},
             {(pos == 1) && !owner_d, (pos == 1) && owner_d,
              (pos >= 4) && (pos <= 7) && !owner_d, (pos >= 4) && (pos <= 7) && owner_d});
         if (pos == 4)
            chk($sformatf("tie_c%0d_data", c), owner_d ? o_ddata : o_idata,
                owner_d ? 32'hA0 : 32'hDEADBEEF);
         if (c == 24) begin
            i_ireq = 1'b0;
            i_dreq = 1'b0;
         end
      end
      @(negedge Clk);
      chk("tie_after", {o_iack, o_dack, o_ivalid, o_dvalid}, 4'b0000);
      $display("txn tie_sequence");

      add_vec(0, 0, 32'h48, 0, 32'h22222222, 32'h33333333, 32'hDEADBEEF, 32'h11111111, 4);
      run_txn(vecs[nv-1], nv - 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
